// File: rtl/sprite_reg_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_reg_arbiter
// Round-robin arbiter sharing the single port of the sprite/game-state register
// file among NREQ requesters (CPU, ghost-movement engine, score/pellet updater).
// One requester is granted per cycle and drives the register-file port. A
// registered ack/rdata follows each access one cycle later. A bounded lock
// keeps the grant for atomic read-modify-write sequences.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req[NREQ]         per-requester access request (level)
//   lock[NREQ]        keep grant after this access (meaningful only with req)
//   addr[NREQ*AW]     requester i address in [i*AW +: AW]
//   wdata[NREQ*DW]    requester i write data in [i*DW +: DW]
//   we[NREQ]          requester i write enable
//   gnt[NREQ]         registered one-hot (or zero) grant
//   ack[NREQ]         one-cycle pulse: access by requester i completed
//   rdata[DW]         registered read data of the last completed access
//   reg_addr/reg_in/reg_we  register-file port drive
//   reg_out[DW]       register-file combinational read data
// -----------------------------------------------------------------------------
module sprite_reg_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    input  logic [NREQ-1:0]      we,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        reg_addr,
    output logic [DW-1:0]        reg_in,
    output logic                 reg_we,
    input  logic [DW-1:0]        reg_out
);

    localparam int LW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_LOCK + 1);

    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [DW-1:0]   r_rdata;
    logic [HW-1:0]   r_hold_cnt;
    logic [LW-1:0]   r_last;

    logic [LW-1:0]   w_owner;
    logic            w_access;
    logic            w_hold;
    logic [LW-1:0]   w_next_owner;
    logic            w_any_req;

    // Index of the (one-hot) grant bit; zero when nothing is granted.
    always_comb begin
        w_owner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) w_owner = LW'(i);
        end
    end

    // An access happens only when the owner is still requesting.
    assign w_access = |(r_gnt & req);
    assign w_hold   = w_access && lock[w_owner] && (r_hold_cnt < HW'(MAX_LOCK - 1));

    // Rotating search starting just after the last winner, wrapping to it.
    always_comb begin
        int unsigned v_idx;
        v_idx        = 0;
        w_any_req    = 1'b0;
        w_next_owner = r_last;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            v_idx = (32'(r_last) + i) % NREQ;
            if (!w_any_req && req[v_idx[LW-1:0]]) begin
                w_any_req    = 1'b1;
                w_next_owner = v_idx[LW-1:0];
            end
        end
    end

    // Port drive follows the grant; idle or wasted cycles present zeros.
    always_comb begin
        reg_addr = '0;
        reg_in   = '0;
        reg_we   = 1'b0;
        if (w_access) begin
            reg_addr = addr[w_owner*AW +: AW];
            reg_in   = wdata[w_owner*DW +: DW];
            reg_we   = we[w_owner] & ~reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_hold_cnt <= '0;
            r_last     <= LW'(NREQ - 1);
        end else begin
            r_ack <= '0;
            if (w_access) begin
                r_ack[w_owner] <= 1'b1;
                // Captured before the write lands, so writes return the old value.
                r_rdata        <= reg_out;
            end
            if (w_hold) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end else begin
                r_hold_cnt <= '0;
                r_gnt      <= '0;
                if (w_any_req) begin
                    r_gnt[w_next_owner] <= 1'b1;
                    r_last              <= w_next_owner;
                end
            end
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_sprite_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_reg_arbiter
// Bench for sprite_reg_arbiter: directed scenarios plus randomized traffic,
// compared against an integer-level reference model and a shadow register file.
// -----------------------------------------------------------------------------
module tb_sprite_reg_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 6;
    localparam int DW       = 16;
    localparam int MAX_LOCK = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0, lock = '0, we = '0;
    logic [NREQ*AW-1:0]  addr = '0;
    logic [NREQ*DW-1:0]  wdata = '0;
    logic [NREQ-1:0]     gnt, ack;
    logic [DW-1:0]       rdata, reg_in, reg_out;
    logic [AW-1:0]       reg_addr;
    logic                reg_we;

    // Bench-side register file
    logic [DW-1:0] mem [64];
    logic          fill = 1'b0, poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;

    // Reference model state
    int            m_owner = -1, m_last = NREQ - 1, m_hold = 0;
    logic [DW-1:0] shadow [64];
    logic [DW-1:0] m_rdata = '0;
    logic [NREQ-1:0] m_ack = '0;
    logic [AW-1:0] e_addr, o_addr;
    logic [DW-1:0] e_in, o_in;
    logic          e_we, o_we;

    int n_checks = 0, n_pass = 0;

    sprite_reg_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr),
        .wdata(wdata), .we(we), .gnt(gnt), .ack(ack), .rdata(rdata),
        .reg_addr(reg_addr), .reg_in(reg_in), .reg_we(reg_we), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fillval(input int i);
        return DW'((i * 291) ^ 23130);
    endfunction

    assign reg_out = mem[reg_addr];

    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 64; i++) mem[i] <= fillval(i);
        if (poke_en) mem[poke_a] <= poke_d;
        if (reg_we) mem[reg_addr] <= reg_in;
    end

    function automatic logic [NREQ-1:0] egnt();
        return (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
    endfunction

    // Advance one clock: capture port drive mid-cycle, step the model, cross the edge.
    task automatic tick();
        bit acc;
        int nxt;
        #2;
        acc    = (m_owner >= 0) && req[m_owner];
        e_addr = acc ? addr[m_owner*AW +: AW] : '0;
        e_in   = acc ? wdata[m_owner*DW +: DW] : '0;
        e_we   = acc && we[m_owner] && !reset;
        o_addr = reg_addr; o_in = reg_in; o_we = reg_we;
        if (reset) begin
            m_owner = -1; m_last = NREQ - 1; m_hold = 0; m_ack = '0; m_rdata = '0;
        end else begin
            if (acc) begin
                m_ack   = NREQ'(1 << m_owner);
                m_rdata = shadow[e_addr];
                if (we[m_owner]) shadow[e_addr] = e_in;
            end else m_ack = '0;
            if (acc && lock[m_owner] && m_hold < MAX_LOCK - 1) m_hold++;
            else begin
                m_hold = 0; nxt = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (nxt < 0 && req[(m_last + k) % NREQ]) nxt = (m_last + k) % NREQ;
                m_owner = nxt;
                if (nxt >= 0) m_last = nxt;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic set_rq(input int i, input bit r, input bit l, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r; lock[i] = l; we[i] = w;
        addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d; shadow[a] = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs(); reset = 1'b1; fill = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = fillval(i);
        tick();
        fill = 1'b0;
        poke(6'd8, 16'h0042);
        poke(6'd26, 16'h0100);
        n_checks++; if (gnt !== 3'b000) $display("FAIL rst_gnt: got %b expected 000", gnt); else n_pass++;
        n_checks++; if (ack !== 3'b000) $display("FAIL rst_ack: got %b expected 000", ack); else n_pass++;
        n_checks++; if (rdata !== 16'h0000) $display("FAIL rst_rdata: got %h expected 0000", rdata); else n_pass++;
        n_checks++; if (o_we !== 1'b0) $display("FAIL rst_reg_we: got %b expected 0", o_we); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_rq(1, 1, 0, 0, 6'd8, 16'h0000);
        tick();
        n_checks++; if (gnt !== 3'b010) $display("FAIL sr_gnt: got %b expected 010", gnt); else n_pass++;
        tick();
        n_checks++; if (o_addr !== 6'd8) $display("FAIL sr_reg_addr: got %0d expected 8", o_addr); else n_pass++;
        n_checks++; if (ack !== 3'b010) $display("FAIL sr_ack: got %b expected 010", ack); else n_pass++;
        n_checks++; if (rdata !== 16'h0042) $display("FAIL sr_rdata: got %h expected 0042", rdata); else n_pass++;
        req[1] = 1'b0;
        tick();
        n_checks++; if (gnt !== 3'b000) $display("FAIL sr_gnt_idle: got %b expected 000", gnt); else n_pass++;
        n_checks++; if (ack !== 3'b000) $display("FAIL sr_ack_wasted: got %b expected 000", ack); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] prev, want;
        do_reset();
        set_rq(0, 1, 0, 0, 6'd1, 16'h0);
        set_rq(1, 1, 0, 0, 6'd2, 16'h0);
        set_rq(2, 1, 0, 0, 6'd3, 16'h0);
        prev = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            want = NREQ'(1 << (k % 3));
            n_checks++; if (gnt !== want) $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, want); else n_pass++;
            n_checks++; if (ack !== prev) $display("FAIL rr_ack[%0d]: got %b expected %b", k, ack, prev); else n_pass++;
            n_checks++; if (rdata !== m_rdata) $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rdata, m_rdata); else n_pass++;
            prev = want;
        end
    endtask

    task automatic test_locked_rmw();
        do_reset();
        set_rq(0, 1, 0, 0, 6'd3, 16'h0);
        set_rq(2, 1, 1, 0, 6'd26, 16'h0);
        tick();
        n_checks++; if (gnt !== 3'b001) $display("FAIL rmw_gnt0: got %b expected 001", gnt); else n_pass++;
        tick();
        n_checks++; if (gnt !== 3'b100) $display("FAIL rmw_gnt2a: got %b expected 100", gnt); else n_pass++;
        tick();
        n_checks++; if (gnt !== 3'b100) $display("FAIL rmw_gnt2b: got %b expected 100", gnt); else n_pass++;
        n_checks++; if (rdata !== 16'h0100) $display("FAIL rmw_read: got %h expected 0100", rdata); else n_pass++;
        set_rq(2, 1, 0, 1, 6'd26, 16'h0110);
        tick();
        n_checks++; if (gnt !== 3'b001) $display("FAIL rmw_gnt_after: got %b expected 001", gnt); else n_pass++;
        n_checks++; if (ack !== 3'b100) $display("FAIL rmw_ack: got %b expected 100", ack); else n_pass++;
        n_checks++; if (rdata !== 16'h0100) $display("FAIL rmw_prewrite: got %h expected 0100", rdata); else n_pass++;
        n_checks++; if (mem[26] !== 16'h0110) $display("FAIL rmw_reg26: got %h expected 0110", mem[26]); else n_pass++;
    endtask

    task automatic test_lock_bound();
        int cnt;
        do_reset();
        set_rq(0, 1, 1, 0, 6'd10, 16'h0);
        set_rq(1, 1, 0, 0, 6'd11, 16'h0);
        tick();
        cnt = 0;
        while (gnt === 3'b001 && cnt < 20) begin
            cnt++;
            tick();
            n_checks++; if (gnt !== egnt()) $display("FAIL lb_gnt[%0d]: got %b expected %b", cnt, gnt, egnt()); else n_pass++;
        end
        n_checks++; if (cnt !== MAX_LOCK) $display("FAIL lb_count: got %0d expected %0d", cnt, MAX_LOCK); else n_pass++;
        n_checks++; if (gnt !== 3'b010) $display("FAIL lb_next: got %b expected 010", gnt); else n_pass++;
    endtask

    task automatic test_dropped_request();
        do_reset();
        set_rq(1, 1, 0, 0, 6'd4, 16'h0);
        tick();
        set_rq(0, 1, 0, 1, 6'd5, 16'hDEAD);
        tick();
        n_checks++; if (gnt !== 3'b001) $display("FAIL dr_gnt0: got %b expected 001", gnt); else n_pass++;
        req[0] = 1'b0;
        tick();
        n_checks++; if (o_we !== 1'b0) $display("FAIL dr_reg_we: got %b expected 0", o_we); else n_pass++;
        n_checks++; if (o_addr !== 6'd0) $display("FAIL dr_reg_addr: got %0d expected 0", o_addr); else n_pass++;
        n_checks++; if (ack !== 3'b000) $display("FAIL dr_ack: got %b expected 000", ack); else n_pass++;
        n_checks++; if (gnt !== 3'b010) $display("FAIL dr_gnt1: got %b expected 010", gnt); else n_pass++;
        n_checks++; if (mem[5] !== fillval(5)) $display("FAIL dr_mem5: got %h expected %h", mem[5], fillval(5)); else n_pass++;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_rq(1, 1, 1, 1, 6'd30, 16'hBEEF);
        tick();
        tick();
        n_checks++; if (gnt !== 3'b010) $display("FAIL rml_held: got %b expected 010", gnt); else n_pass++;
        set_rq(1, 1, 1, 1, 6'd31, 16'hCAFE);
        reset = 1'b1;
        tick();
        n_checks++; if (o_we !== 1'b0) $display("FAIL rml_reg_we: got %b expected 0", o_we); else n_pass++;
        n_checks++; if (mem[31] !== fillval(31)) $display("FAIL rml_nowrite: got %h expected %h", mem[31], fillval(31)); else n_pass++;
        n_checks++; if (gnt !== 3'b000) $display("FAIL rml_gnt: got %b expected 000", gnt); else n_pass++;
        n_checks++; if (ack !== 3'b000) $display("FAIL rml_ack: got %b expected 000", ack); else n_pass++;
        n_checks++; if (rdata !== 16'h0000) $display("FAIL rml_rdata: got %h expected 0000", rdata); else n_pass++;
        reset = 1'b0;
        clear_inputs();
        set_rq(0, 1, 0, 0, 6'd1, 16'h0);
        set_rq(1, 1, 0, 0, 6'd2, 16'h0);
        tick();
        n_checks++; if (gnt !== 3'b001) $display("FAIL rml_first: got %b expected 001", gnt); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_rq(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                       $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63)), DW'($urandom));
            reset = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++; if (o_addr !== e_addr) $display("FAIL rnd_reg_addr[%0d]: got %h expected %h", c, o_addr, e_addr); else n_pass++;
            n_checks++; if (o_in !== e_in) $display("FAIL rnd_reg_in[%0d]: got %h expected %h", c, o_in, e_in); else n_pass++;
            n_checks++; if (o_we !== e_we) $display("FAIL rnd_reg_we[%0d]: got %b expected %b", c, o_we, e_we); else n_pass++;
            n_checks++; if (gnt !== egnt()) $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, egnt()); else n_pass++;
            n_checks++; if (ack !== m_ack) $display("FAIL rnd_ack[%0d]: got %b expected %b", c, ack, m_ack); else n_pass++;
            n_checks++; if (rdata !== m_rdata) $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, rdata, m_rdata); else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked_rmw();
        test_lock_bound();
        test_dropped_request();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_reg_arbiter.md
# sprite_reg_arbiter

Round-robin arbiter sharing the single port of the sprite/game-state register file (6-bit address, 16-bit data, combinational read, write on posedge) among NREQ requesters: the CPU, the ghost-movement engine and the score/pellet updater. It grants one requester per cycle and drives the register-file port from that requester. It returns a registered read-data/acknowledge one cycle after each access. A bounded lock lets a requester perform atomic read-modify-write sequences, for example the score increment at address 26.

## Interface
- NREQ, 3, number of requesters (2..8)
- AW, 6, register address width
- DW, 16, register data width
- MAX_LOCK, 8, maximum consecutive granted cycles under lock (≥1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester access request; level, one access per granted cycle
- lock  in  NREQ  keep grant after this access (valid only with req)
- addr  in  NREQ*AW  requester i address in bits [i*AW +: AW]
- wdata  in  NREQ*DW  requester i write data in bits [i*DW +: DW]
- we  in  NREQ  requester i write enable
- gnt  out  NREQ  registered one-hot (or zero) grant
- ack  out  NREQ  one-cycle pulse: access by requester i completed
- rdata  out  DW  registered read data of the last completed access
- reg_addr  out  AW  register-file address
- reg_in  out  DW  register-file write data
- reg_we  out  1  register-file write enable
- reg_out  in  DW  register-file combinational read data

## Operation
- Owner o is the index of the set gnt bit. An access occurs in every cycle with gnt[o] & req[o].
- Port drive (combinational from gnt):
  - During an access cycle: reg_addr = addr[o], reg_in = wdata[o], reg_we = we[o].
  - When gnt = 0, or gnt[o] is set with req[o] low: reg_addr = 0, reg_in = 0, reg_we = 0.
  - reg_we is forced 0 while reset is high.
- Completion: on the edge that ends an access cycle, ack[o] <= 1 and rdata <= reg_out. On writes, rdata receives the pre-write value, which enables read-modify-write.
  - On all other edges, ack <= 0 and rdata holds its value.
- Arbitration is evaluated at every posedge from the current req, lock, gnt and a pointer last.
  - Lock hold: if this cycle was an access by o with lock[o] = 1 and hold_cnt < MAX_LOCK-1, then gnt stays o and hold_cnt increments.
  - Otherwise, hold_cnt <= 0 and the search order is last+1, last+2, …, last (mod NREQ). The new owner is the first index with req = 1; gnt <= one-hot(new owner) and last <= new owner.
  - If no req is set, gnt <= 0 and last is unchanged.
- A sole requester is regranted every cycle, giving 1 access per cycle.
- A requester that drops req while granted wastes that cycle: no access and no ack.
- A lock held on a cycle with no access is ignored; normal rotation applies.
- Requesters may change addr, wdata and we on every granted cycle (streaming). Signals of non-granted requesters are ignored.
- Reset values: gnt = 0, ack = 0, rdata = 0, hold_cnt = 0, last = NREQ-1, so requester 0 wins first.

## Timing
- Request-to-grant: req rising in cycle n gives gnt in cycle n+1 if the requester wins; the access occurs in cycle n+1.
- Access-to-ack: an access in cycle k gives ack and valid rdata in cycle k+1.
- req-to-ack latency is 2 cycles minimum.
- A write lands in the register file at the end of the access cycle. A read of the same address in the next granted cycle returns the new value.
- Locked sequences give at most MAX_LOCK consecutive accesses to one owner. Worst-case wait for a continuously requesting requester is (NREQ-1)*MAX_LOCK + 1 cycles.
- Reset mid-operation: the cycle with reset high performs no write. On the following edge, gnt, ack, rdata, hold_cnt and last take their reset values regardless of req or lock. In-flight locks are lost.

## Test plan
- Single read:
  - Stimulus: req[1] = 1, addr = 8, we = 0 for one cycle; register 8 holds 0x0042.
  - Required: gnt[1] in cycle 1, reg_addr = 8, ack[1] in cycle 2, rdata = 0x0042, gnt = 0 in cycle 3.
- Round robin:
  - Stimulus: req = 3'b111 held, no lock, from reset.
  - Required: gnt sequence 001, 010, 100, 001…, with ack following one cycle behind each grant.
- Locked read-modify-write:
  - Stimulus: requester 2 reads addr 26 (value 0x0100) with lock = 1, then writes addr 26 with 0x0110 and lock = 0; requester 0 requests throughout.
  - Required: gnt[2] on two consecutive cycles, register 26 becomes 0x0110, then gnt[0].
- Lock bound:
  - Stimulus: MAX_LOCK = 8; requester 0 holds req and lock continuously; requester 1 requests.
  - Required: exactly 8 consecutive gnt[0] cycles, then gnt[1].
- Dropped request:
  - Stimulus: requester 0 pulses req for one cycle while another requester is granted.
  - Required: gnt[0] appears after req has dropped; reg_we = 0, reg_addr = 0 and no ack[0] that cycle.
- Reset mid-lock:
  - Stimulus: assert reset during a locked write by requester 1.
  - Required: reg_we = 0 that cycle; next cycle gnt = 0, ack = 0, rdata = 0; after release, with req = 3'b011, requester 0 is granted first.
